// File: rtl/exe_pipe_mc_if.sv
// Execute-stage bus: instruction/operand inputs from decode and the
// EXE/MEM register outputs toward memory. The pipeline controller side is
// the master, the execute stage is the slave.
interface exe_pipe_mc_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 4
);
  logic              freeze;
  logic              flush;
  logic              valid_in;
  logic              WB_EN_in;
  logic              MEM_R_EN_in;
  logic              MEM_W_EN_in;
  logic              imm;
  logic [3:0]        EXE_CMD;
  logic [3:0]        SRin;
  logic [REG_AW-1:0] dst_in;
  logic [1:0]        Sel_src1;
  logic [1:0]        Sel_src2;
  logic [WIDTH-1:0]  Val_Rn;
  logic [WIDTH-1:0]  Val_Rm;
  logic [WIDTH-1:0]  Val2;
  logic [WIDTH-1:0]  ALU_MEM_val;
  logic [WIDTH-1:0]  WB_Val;

  logic              stall;
  logic [3:0]        SR;
  logic              valid;
  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [REG_AW-1:0] Dest;
  logic [WIDTH-1:0]  ALU_result;
  logic [WIDTH-1:0]  Val_Rm_out;

  modport master (
    output freeze, flush, valid_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, imm,
           EXE_CMD, SRin, dst_in, Sel_src1, Sel_src2,
           Val_Rn, Val_Rm, Val2, ALU_MEM_val, WB_Val,
    input  stall, SR, valid, WB_EN, MEM_R_EN, MEM_W_EN, Dest, ALU_result, Val_Rm_out
  );

  modport slave (
    input  freeze, flush, valid_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, imm,
           EXE_CMD, SRin, dst_in, Sel_src1, Sel_src2,
           Val_Rn, Val_Rm, Val2, ALU_MEM_val, WB_Val,
    output stall, SR, valid, WB_EN, MEM_R_EN, MEM_W_EN, Dest, ALU_result, Val_Rm_out
  );
endinterface

// File: rtl/exe_pipe_mc.sv
// Execute stage with operand forwarding, ALU, flags and the EXE/MEM register.
// Optional macro EXE_PIPE_MUL_EN adds a multi-cycle shift-add multiplier;
// without it MUL is a single-cycle op producing 0 and stall is tied low.
module exe_pipe_mc #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 4
) (
  input logic          clk,
  input logic          rst,
  exe_pipe_mc_if.slave bus
);
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] fwd_rm;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH:0]   add_sum;
  logic             c_d;
  logic             v_d;
  logic             stall;

  logic              valid_q, wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [REG_AW-1:0] dest_q;
  logic [WIDTH-1:0]  alu_result_q, val_rm_q;

`ifdef EXE_PIPE_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic             mul_req;
`endif

  // Forwarding muxes: select 3 falls back to the register file value
  always_comb begin
    case (bus.Sel_src1)
      2'd1:    op_a = bus.ALU_MEM_val;
      2'd2:    op_a = bus.WB_Val;
      default: op_a = bus.Val_Rn;
    endcase
    case (bus.Sel_src2)
      2'd1:    fwd_rm = bus.ALU_MEM_val;
      2'd2:    fwd_rm = bus.WB_Val;
      default: fwd_rm = bus.Val_Rm;
    endcase
    op_b = bus.imm ? bus.Val2 : fwd_rm;
  end

  // ALU: subtraction is A + ~B + carry so the carry-out is the no-borrow flag
  always_comb begin
    result_d = '0;
    add_sum  = '0;
    c_d      = bus.SRin[1];
    v_d      = bus.SRin[0];
    case (bus.EXE_CMD)
      CMD_MOV: result_d = op_b;
      CMD_MVN: result_d = ~op_b;
      CMD_ADD, CMD_ADC: begin
        add_sum  = {1'b0, op_a} + {1'b0, op_b}
                 + {{WIDTH{1'b0}}, (bus.EXE_CMD == CMD_ADC) & bus.SRin[1]};
        result_d = add_sum[WIDTH-1:0];
        c_d      = add_sum[WIDTH];
        v_d      = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (add_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      CMD_SUB, CMD_SBC: begin
        add_sum  = {1'b0, op_a} + {1'b0, ~op_b}
                 + {{WIDTH{1'b0}}, (bus.EXE_CMD == CMD_SUB) | bus.SRin[1]};
        result_d = add_sum[WIDTH-1:0];
        c_d      = add_sum[WIDTH];
        v_d      = (op_a[WIDTH-1] != op_b[WIDTH-1]) & (add_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      CMD_AND: result_d = op_a & op_b;
      CMD_ORR: result_d = op_a | op_b;
      CMD_EOR: result_d = op_a ^ op_b;
`ifdef EXE_PIPE_MUL_EN
      CMD_MUL: result_d = acc_q;
`else
      CMD_MUL: result_d = '0;
`endif
      default: result_d = '0;
    endcase
  end

  assign bus.SR = {result_d[WIDTH-1], (result_d == '0), c_d, v_d};

`ifdef EXE_PIPE_MUL_EN
  assign mul_req = bus.valid_in & (bus.EXE_CMD == CMD_MUL);
  assign stall   = ((state_q == S_IDLE) & mul_req) | (state_q == S_BUSY);

  // Multiplier FSM: operands latched on start, one multiplier bit consumed per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (bus.flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (!bus.freeze) begin
      case (state_q)
        S_IDLE: begin
          if (mul_req) begin
            state_q  <= S_BUSY;
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        S_BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  assign stall = 1'b0;
`endif

  assign bus.stall = stall;

  // EXE/MEM register: bubbles clear only valid and enables, data fields are don't-care
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      dest_q       <= '0;
      alu_result_q <= '0;
      val_rm_q     <= '0;
    end else if (bus.flush) begin
      valid_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
    end else if (!bus.freeze) begin
      if (stall || !bus.valid_in) begin
        valid_q    <= 1'b0;
        wb_en_q    <= 1'b0;
        mem_r_en_q <= 1'b0;
        mem_w_en_q <= 1'b0;
      end else begin
        valid_q      <= 1'b1;
        wb_en_q      <= bus.WB_EN_in;
        mem_r_en_q   <= bus.MEM_R_EN_in;
        mem_w_en_q   <= bus.MEM_W_EN_in;
        dest_q       <= bus.dst_in;
        alu_result_q <= result_d;
        val_rm_q     <= fwd_rm;
      end
    end
  end

  assign bus.valid      = valid_q;
  assign bus.WB_EN      = wb_en_q;
  assign bus.MEM_R_EN   = mem_r_en_q;
  assign bus.MEM_W_EN   = mem_w_en_q;
  assign bus.Dest       = dest_q;
  assign bus.ALU_result = alu_result_q;
  assign bus.Val_Rm_out = val_rm_q;
endmodule

// File: tb/tb_exe_pipe_mc.sv
// Bench for exe_pipe_mc: randomized single-cycle ops against an arithmetic
// reference model, directed boundary cases, and multiplier scenarios when
// EXE_PIPE_MUL_EN is defined.
module tb_exe_pipe_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exe_pipe_mc_if #(.WIDTH(32), .REG_AW(4)) bus ();
  exe_pipe_mc #(.WIDTH(32), .REG_AW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.freeze = 0; bus.flush = 0; bus.valid_in = 0;
    bus.WB_EN_in = 0; bus.MEM_R_EN_in = 0; bus.MEM_W_EN_in = 0; bus.imm = 0;
    bus.EXE_CMD = 0; bus.SRin = 0; bus.dst_in = 0; bus.Sel_src1 = 0; bus.Sel_src2 = 0;
    bus.Val_Rn = 0; bus.Val_Rm = 0; bus.Val2 = 0; bus.ALU_MEM_val = 0; bus.WB_Val = 0;
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rn,
                                      input logic [31:0] amv, input logic [31:0] wbv);
    if (sel == 2'd1) return amv;
    if (sel == 2'd2) return wbv;
    return rn;
  endfunction

  // Reference ALU from exact integer arithmetic: returns {N,Z,C,V, result}
  function automatic logic [35:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] sr);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned full;
    longint          exact;
    logic [31:0]     r = 32'd0;
    logic            c = sr[1];
    logic            v = sr[0];
    logic            k;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd2, 4'd3: begin
        k = (cmd == 4'd3) ? sr[1] : 1'b0;
        full = ua + ub + longint'(k);
        r = full[31:0];
        c = full[32];
        exact = sa + sb + longint'(k);
        v = (exact != longint'($signed(r)));
      end
      4'd4, 4'd5: begin
        k = (cmd == 4'd5) ? !sr[1] : 1'b0;
        full = ua - ub - longint'(k);
        r = full[31:0];
        c = (ua >= ub + longint'(k));
        exact = sa - sb - longint'(k);
        v = (exact != longint'($signed(r)));
      end
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd10: begin
`ifdef EXE_PIPE_MUL_EN
        full = ua * ub;
        r = full[31:0];
`else
        r = 32'd0;
`endif
      end
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

`ifdef EXE_PIPE_MUL_EN
  task automatic mul_start(input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    bus.valid_in = 1; bus.EXE_CMD = 4'd10; bus.WB_EN_in = 1; bus.dst_in = 4'd5;
    bus.Val_Rn = a; bus.Val_Rm = b;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] m;
    logic [31:0] a, rm, b;
    logic        e_valid, e_wb, e_mr, e_mw;
    logic [3:0]  e_dest;
    logic [31:0] e_res, e_rm;
    logic [3:0]  cmd;
    int          n;
    logic        seen;
    logic [31:0] ra, rb;

    idle_inputs();
    rst = 1;
    repeat (2) tick();
    check_val("rst_valid", bus.valid, 0);
    check_val("rst_ctrl", {bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, 0);
    check_val("rst_dest", bus.Dest, 0);
    check_val("rst_result", bus.ALU_result, 0);
    check_val("rst_rm", bus.Val_Rm_out, 0);
    check_val("rst_stall", bus.stall, 0);
    rst = 0;

    // Boundary: ADD wraps to zero with carry
    idle_inputs();
    bus.valid_in = 1; bus.EXE_CMD = 4'd2; bus.Val_Rn = 32'hFFFF_FFFF; bus.Val_Rm = 32'd1;
    #1;
    check_val("add_wrap_sr", bus.SR, 4'b0110);
    check_val("add_wrap_stall", bus.stall, 0);
    tick();
    check_val("add_wrap_res", bus.ALU_result, 32'd0);
    check_val("add_wrap_valid", bus.valid, 1);
    $display("txn add_wrap res=%h", bus.ALU_result);

    // Boundary: SUB overflow with A forwarded from WB
    idle_inputs();
    bus.valid_in = 1; bus.EXE_CMD = 4'd4; bus.Sel_src1 = 2'd2; bus.WB_Val = 32'h8000_0000;
    bus.Val_Rn = 32'h1234_5678; bus.imm = 1; bus.Val2 = 32'd1;
    #1;
    check_val("sub_ovf_sr", bus.SR, 4'b0011);
    tick();
    check_val("sub_ovf_res", bus.ALU_result, 32'h7FFF_FFFF);
    check_val("sub_ovf_valid", bus.valid, 1);
    $display("txn sub_ovf res=%h", bus.ALU_result);

    e_valid = bus.valid; e_wb = bus.WB_EN; e_mr = bus.MEM_R_EN; e_mw = bus.MEM_W_EN;
    e_dest = bus.Dest; e_res = 32'h7FFF_FFFF; e_rm = 32'd0;
    e_wb = 0; e_mr = 0; e_mw = 0; e_dest = 0;

    // Randomized single-cycle traffic with occasional flush, freeze and idle slots
    for (int i = 0; i < 80; i++) begin
      cmd = 4'($urandom_range(0, 15));
`ifdef EXE_PIPE_MUL_EN
      if (cmd == 4'd10) cmd = 4'd2;
`endif
      bus.EXE_CMD = cmd;
      bus.Val_Rn = pick_val(); bus.Val_Rm = pick_val(); bus.Val2 = pick_val();
      bus.ALU_MEM_val = pick_val(); bus.WB_Val = pick_val();
      bus.Sel_src1 = 2'($urandom_range(0, 3)); bus.Sel_src2 = 2'($urandom_range(0, 3));
      bus.imm = 1'($urandom_range(0, 1)); bus.SRin = 4'($urandom_range(0, 15));
      bus.WB_EN_in = 1'($urandom_range(0, 1)); bus.MEM_R_EN_in = 1'($urandom_range(0, 1));
      bus.MEM_W_EN_in = 1'($urandom_range(0, 1)); bus.dst_in = 4'($urandom_range(0, 15));
      bus.valid_in = ($urandom_range(0, 7) != 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.freeze = ($urandom_range(0, 9) == 0);
      a  = fwd(bus.Sel_src1, bus.Val_Rn, bus.ALU_MEM_val, bus.WB_Val);
      rm = fwd(bus.Sel_src2, bus.Val_Rm, bus.ALU_MEM_val, bus.WB_Val);
      b  = bus.imm ? bus.Val2 : rm;
      m  = ref_alu(cmd, a, b, bus.SRin);
      #1;
      check_val("rnd_sr", bus.SR, m[35:32]);
      check_val("rnd_stall", bus.stall, 0);
      if (bus.flush) begin
        e_valid = 0; e_wb = 0; e_mr = 0; e_mw = 0;
      end else if (!bus.freeze) begin
        if (!bus.valid_in) begin
          e_valid = 0; e_wb = 0; e_mr = 0; e_mw = 0;
        end else begin
          e_valid = 1; e_wb = bus.WB_EN_in; e_mr = bus.MEM_R_EN_in; e_mw = bus.MEM_W_EN_in;
          e_dest = bus.dst_in; e_res = m[31:0]; e_rm = rm;
        end
      end
      tick();
      check_val("rnd_valid", bus.valid, e_valid);
      check_val("rnd_ctrl", {bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, {e_wb, e_mr, e_mw});
      if (e_valid) begin
        check_val("rnd_dest", bus.Dest, e_dest);
        check_val("rnd_result", bus.ALU_result, e_res);
        check_val("rnd_rm_out", bus.Val_Rm_out, e_rm);
      end
      $display("txn %0d cmd=%0d A=%h B=%h fl=%b fz=%b vin=%b valid=%b res=%h",
               i, cmd, a, b, bus.flush, bus.freeze, bus.valid_in, bus.valid, bus.ALU_result);
    end

    // Reset after a committed instruction clears the EXE/MEM register
    idle_inputs();
    bus.valid_in = 1; bus.EXE_CMD = 4'd7; bus.Val_Rn = 32'hF0; bus.Val_Rm = 32'h0F;
    bus.WB_EN_in = 1; bus.dst_in = 4'd9;
    tick();
    check_val("orr_res", bus.ALU_result, 32'hFF);
    rst = 1;
    tick();
    rst = 0;
    check_val("rst2_valid", bus.valid, 0);
    check_val("rst2_all", {bus.WB_EN, bus.Dest, bus.ALU_result, bus.Val_Rm_out}, 0);
    $display("txn reset_after_orr valid=%b", bus.valid);

`ifndef EXE_PIPE_MUL_EN
    // Without the multiplier, MUL is single cycle, result 0, C/V from SRin
    idle_inputs();
    bus.valid_in = 1; bus.EXE_CMD = 4'd10; bus.Val_Rn = 32'd7; bus.Val_Rm = 32'd6;
    bus.SRin = 4'b0011;
    #1;
    check_val("mul_off_stall", bus.stall, 0);
    check_val("mul_off_sr", bus.SR, 4'b0111);
    tick();
    check_val("mul_off_valid", bus.valid, 1);
    check_val("mul_off_res", bus.ALU_result, 32'd0);
    $display("txn mul_disabled res=%h", bus.ALU_result);
`else
    // 7*6: WIDTH+1 stall cycles of bubbles, then a single commit
    mul_start(32'd7, 32'd6);
    for (int i = 0; i < 33; i++) begin
      #1;
      check_val("mul_stall_hi", bus.stall, 1);
      tick();
      check_val("mul_bubble", bus.valid, 0);
    end
    check_val("mul_done_stall", bus.stall, 0);
    tick();
    check_val("mul_commit_valid", bus.valid, 1);
    check_val("mul_commit_res", bus.ALU_result, 32'd42);
    check_val("mul_commit_dest", {bus.WB_EN, bus.Dest}, {1'b1, 4'd5});
    idle_inputs();
    #1;
    check_val("mul_after_stall", bus.stall, 0);
    tick();
    check_val("mul_once", bus.valid, 0);
    $display("txn mul 7*6 res=42");

    // Random operands via forwarding, sources changed after capture, freeze mid-BUSY
    ra = $urandom; rb = $urandom;
    mul_start(32'd0, 32'd0);
    bus.Sel_src1 = 2'd1; bus.ALU_MEM_val = ra;
    bus.Sel_src2 = 2'd2; bus.WB_Val = rb;
    n = 0;
    while (bus.stall && n < 100) begin
      bus.freeze = (n == 10 || n == 11);
      n++;
      tick();
      bus.ALU_MEM_val = $urandom; bus.WB_Val = $urandom;
      #1;
    end
    bus.freeze = 0;
    check_val("mul_stall_len", n, 35);
    tick();
    check_val("mul_rnd_valid", bus.valid, 1);
    check_val("mul_rnd_res", bus.ALU_result, ref_alu(4'd10, ra, rb, 4'd0) & 36'hFFFFFFFF);
    idle_inputs();
    tick();
    $display("txn mul %h*%h res=%h stall_cycles=%0d", ra, rb, ref_alu(4'd10, ra, rb, 4'd0) & 36'hFFFFFFFF, n);

    // Flush in BUSY cycle 10 aborts the multiply
    mul_start(32'd7, 32'd6);
    repeat (10) tick();
    check_val("flush_pre_stall", bus.stall, 1);
    bus.flush = 1;
    tick();
    idle_inputs();
    check_val("flush_bubble", bus.valid, 0);
    check_val("flush_stall", bus.stall, 0);
    bus.valid_in = 1; bus.EXE_CMD = 4'd2; bus.Val_Rn = 32'd3; bus.Val_Rm = 32'd4;
    #1;
    check_val("flush_add_stall", bus.stall, 0);
    tick();
    check_val("flush_add_valid", bus.valid, 1);
    check_val("flush_add_res", bus.ALU_result, 32'd7);
    idle_inputs();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= bus.valid;
    end
    check_val("flush_no_commit", seen, 0);
    $display("txn mul flushed then add res=7");

    // Freeze in DONE holds outputs, product commits on release
    mul_start(32'd7, 32'd6);
    repeat (33) tick();
    check_val("frz_done_stall", bus.stall, 0);
    bus.freeze = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("frz_hold_valid", bus.valid, 0);
      check_val("frz_hold_stall", bus.stall, 0);
    end
    bus.freeze = 0;
    tick();
    check_val("frz_commit_valid", bus.valid, 1);
    check_val("frz_commit_res", bus.ALU_result, 32'd42);
    idle_inputs();
    tick();
    $display("txn mul frozen in done res=42");

    // Reset during BUSY abandons the multiply
    mul_start(32'd7, 32'd6);
    repeat (5) tick();
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
    check_val("rstb_outputs", {bus.valid, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.Dest}, 0);
    check_val("rstb_data", {bus.ALU_result, bus.Val_Rm_out}, 0);
    check_val("rstb_stall", bus.stall, 0);
    bus.valid_in = 1; bus.EXE_CMD = 4'd2; bus.Val_Rn = 32'h10; bus.Val_Rm = 32'h20;
    tick();
    check_val("rstb_add_valid", bus.valid, 1);
    check_val("rstb_add_res", bus.ALU_result, 32'h30);
    idle_inputs();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= bus.valid;
    end
    check_val("rstb_no_commit", seen, 0);
    $display("txn mul reset in busy then add res=30");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exe_pipe_mc.md
EXE_PIPE_MC -- requirements
Module: exe_pipe_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (>=8).
REQ-002 Parameter REG_AW, default 4, destination register address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 freeze  input  1  downstream hold; EXE/MEM register and multiplier FSM retain state.
REQ-006 flush  input  1  kill instruction currently in EXE.
REQ-007 valid_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, imm  input  1 each  instruction valid, control enables, immediate select.
REQ-008 EXE_CMD  input  4  operation; SRin  input  4  flags {N,Z,C,V}.
REQ-009 dst_in  input  REG_AW  destination register.
REQ-010 Sel_src1, Sel_src2  input  2 each  forwarding selects.
REQ-011 Val_Rn, Val_Rm, Val2, ALU_MEM_val, WB_Val  input  WIDTH each  operands, immediate operand, forward sources.
REQ-012 stall  output  1  upstream must hold the EXE instruction stable.
REQ-013 SR  output  4  combinational {N,Z,C,V} of current EXE result.
REQ-014 valid, WB_EN, MEM_R_EN, MEM_W_EN  output  1 each; Dest  output  REG_AW; ALU_result, Val_Rm_out  output  WIDTH; all registered.

Function
REQ-015 Forwarded A = Sel_src1 {0:Val_Rn, 1:ALU_MEM_val, 2:WB_Val, 3:Val_Rn}; forwarded Rm same mapping on Sel_src2; B = imm ? Val2 : forwarded Rm.
REQ-016 EXE_CMD: 0001 MOV B; 1001 MVN ~B; 0010 ADD; 0011 ADC (+C); 0100 SUB; 0101 SBC (A-B-!C); 0110 AND; 0111 ORR; 1000 EOR; 1010 MUL; others result 0.
REQ-017 Arithmetic modulo 2^WIDTH; C = carry-out (add) or no-borrow (sub); V = signed overflow; logic ops and MUL pass C,V from SRin; N = MSB; Z = result==0.
REQ-018 Non-MUL ops: single cycle; EXE/MEM register loads result, controls, Dest, forwarded Rm at the edge when not frozen.
REQ-019 Multiplier FSM states IDLE, BUSY, DONE; shift-add, one multiplier bit per cycle; result = low WIDTH bits of A*B.
REQ-020 IDLE->BUSY when valid_in & EXE_CMD==MUL & !flush & !freeze; A and B captured at that edge (forward sources may change afterwards).
REQ-021 BUSY lasts exactly WIDTH cycles, then DONE; DONE->IDLE on the first edge with !freeze, when the product commits to EXE/MEM.
REQ-022 stall = (IDLE & valid_in & MUL) | BUSY; low in DONE; MUL total stall = WIDTH+1 cycles.
REQ-023 While stall is high and not frozen, EXE/MEM loads a bubble (valid and all enables 0).
REQ-024 freeze holds EXE/MEM and FSM state and counter; stall value unchanged by freeze.
REQ-025 flush: EXE/MEM loads bubble; FSM forced to IDLE (aborts BUSY/DONE); stall deasserts next cycle.
REQ-026 Priority rst > flush > freeze > normal.
REQ-027 valid_in=0: bubble loaded, no FSM start.

Reset
REQ-028 On rst: valid, WB_EN, MEM_R_EN, MEM_W_EN = 0; Dest, ALU_result, Val_Rm_out = 0; FSM IDLE; counter 0; stall = 0 next cycle.
REQ-029 rst mid-multiply abandons operation; no partial product commits.

Configuration
REQ-030 Macro EXE_PIPE_MUL_EN defined: multiplier FSM per REQ-019..025.
REQ-031 EXE_PIPE_MUL_EN undefined: no FSM; MUL (1010) is single-cycle with result 0, flags per REQ-017; stall tied 0.

Verification
REQ-032 ADD A=0xFFFFFFFF B=1, WIDTH=32 -> next edge ALU_result=0, SR Z=1 C=1 V=0, valid=1.
REQ-033 SUB A=0x80000000 B=1 via Sel_src1=2 (WB_Val=0x80000000) -> ALU_result=0x7FFFFFFF, V=1, C=1.
REQ-034 MUL A=7 B=6 (MUL_EN) -> stall high 33 cycles, 33 bubbles, then ALU_result=42 valid=1 once.
REQ-035 MUL in BUSY cycle 10 with flush=1 -> bubble, FSM IDLE, stall 0 next cycle, no commit of 42.
REQ-036 MUL in DONE with freeze=1 for 3 cycles -> outputs held, product commits on freeze release.
REQ-037 rst during BUSY -> all outputs 0, stall 0, next ADD executes in one cycle.
